// File: rtl/hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_sb
// Description : Scoreboarded hazard unit for the five-stage (F/D/E/M/W)
//               SIMD AES pipeline.
//               - Scalar and vector operand forwarding into E. M has
//                 priority over W.
//               - Load-use detection between E and D.
//               - One outstanding multi-cycle vector/AES op tracked by a
//                 latency countdown.
//               - Branch flushes that arrive while the data-access unit is
//                 busy are deferred until it is free again.
//               - Saturating count of decode stall cycles, used for
//                 performance debug.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   R   register address width (scalar and vector files)
//   CW  latency countdown width (max multi-cycle latency 2**CW-1)
//   SW  stall-cycle counter width
// Ports
//   clk                      clock; all state updates on the rising edge
//   rst_n                    synchronous active-low reset
//   RA1D, RA2D               source registers of the instruction in D
//   MultiD                   D instruction is multi-cycle
//   RA1E, RA2E, WA3E         source and destination registers in E
//   RegWriteE, RegWriteVE    E writes the scalar / vector file
//   MemtoRegE                E instruction is a load
//   MultiE, LatE             E is multi-cycle, and its latency
//   PCSrcE, BranchTakenE,
//   PCSrcM, PCSrcW           control-flow change indicators
//   RegWrite{,V}{M,W}        scalar/vector write enables in M and W
//   WA3M, WA3W               destinations in M and W
//   BusyDA                   data-access unit busy (freezes the pipe)
//   StallF..StallW           stage stalls
//   FlushD, FlushE           stage flushes
//   Forward{A,B}{,V}E        forwarding selects: 00 regfile, 01 W, 10 M
//   MultiBusy                a multi-cycle op is outstanding
//   MultiDone                one-cycle pulse when its result is ready
//   StallCnt                 saturating count of cycles with StallD=1
// ============================================================================
module hazard_unit_sb #(
    parameter int R  = 5,
    parameter int CW = 4,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [R-1:0]  RA1D,
    input  logic [R-1:0]  RA2D,
    input  logic          MultiD,
    input  logic [R-1:0]  RA1E,
    input  logic [R-1:0]  RA2E,
    input  logic [R-1:0]  WA3E,
    input  logic          RegWriteE,
    input  logic          RegWriteVE,
    input  logic          MemtoRegE,
    input  logic          MultiE,
    input  logic [CW-1:0] LatE,
    input  logic          PCSrcE,
    input  logic          BranchTakenE,
    input  logic          PCSrcM,
    input  logic          PCSrcW,
    input  logic          RegWriteM,
    input  logic          RegWriteVM,
    input  logic          RegWriteW,
    input  logic          RegWriteVW,
    input  logic [R-1:0]  WA3M,
    input  logic [R-1:0]  WA3W,
    input  logic          BusyDA,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          StallW,
    output logic          FlushD,
    output logic          FlushE,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic [1:0]    ForwardAVE,
    output logic [1:0]    ForwardBVE,
    output logic          MultiBusy,
    output logic          MultiDone,
    output logic [SW-1:0] StallCnt
);

    localparam logic [1:0]    c_FWD_RF    = 2'b00;
    localparam logic [1:0]    c_FWD_W     = 2'b01;
    localparam logic [1:0]    c_FWD_M     = 2'b10;
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [SW-1:0] c_STALL_ONE = SW'(1);
    localparam logic [SW-1:0] c_STALL_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;        // cycles left on the outstanding multi op
    logic [R-1:0]  r_busyReg;    // destination of the outstanding multi op
    logic          r_busyVec;    // that destination is in the vector file
    logic          r_flushPend;  // branch seen while BusyDA froze the pipe
    logic [SW-1:0] r_stallCnt;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    logic          w_br;
    logic          w_lu;
    logic          w_cntActive;
    logic          w_busyRegValid;
    logic          w_busyRegHit;
    logic          w_mc;
    logic          w_issue;
    logic [CW-1:0] w_issueLat;

    // Forwarding select for one source operand. The youngest producer (M)
    // wins over W. Scalar register 0 is hard-wired to zero and never
    // forwarded; vector register 0 is an ordinary register.
    function automatic logic [1:0] fwdSel(
        input logic         weM,
        input logic [R-1:0] waM,
        input logic         weW,
        input logic [R-1:0] waW,
        input logic [R-1:0] ra,
        input logic         allowZero
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (weM && (allowZero || (waM != '0)) && (waM == ra)) begin
            sel = c_FWD_M;
        end else if (weW && (allowZero || (waW != '0)) && (waW == ra)) begin
            sel = c_FWD_W;
        end
        return sel;
    endfunction

    assign w_br = BranchTakenE | PCSrcE | PCSrcM | PCSrcW;

    // A load in E whose result a D source needs cannot be forwarded in
    // time; D waits one cycle and a bubble goes into E.
    assign w_lu = MemtoRegE && RegWriteE && (WA3E != '0) &&
                  ((WA3E == RA1D) || (WA3E == RA2D));

    assign w_cntActive = (r_cnt != '0);

    // A scalar destination of 0 produces nothing to wait for.
    assign w_busyRegValid = r_busyVec || (r_busyReg != '0);
    assign w_busyRegHit   = w_busyRegValid &&
                            ((RA1D == r_busyReg) || (RA2D == r_busyReg));

    // Only one multi-cycle op may be in flight, so a second multi op in D
    // waits as well as any reader of the busy destination.
    assign w_mc = w_cntActive && (MultiD || w_busyRegHit);

    // StallE only ever comes from BusyDA, so using BusyDA directly here
    // avoids reading back an output port.
    assign w_issue    = MultiE && !BusyDA && !w_cntActive;
    assign w_issueLat = (LatE == '0) ? c_CNT_ONE : LatE;

    // ------------------------------------------------------------------
    // Outputs. Priority: reset > BusyDA > branch/deferred flush > lu/mc.
    // ------------------------------------------------------------------
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        ForwardAE  = c_FWD_RF;
        ForwardBE  = c_FWD_RF;
        ForwardAVE = c_FWD_RF;
        ForwardBVE = c_FWD_RF;
        MultiBusy  = 1'b0;
        MultiDone  = 1'b0;

        if (rst_n) begin
            ForwardAE  = fwdSel(RegWriteM,  WA3M, RegWriteW,  WA3W, RA1E, 1'b0);
            ForwardBE  = fwdSel(RegWriteM,  WA3M, RegWriteW,  WA3W, RA2E, 1'b0);
            ForwardAVE = fwdSel(RegWriteVM, WA3M, RegWriteVW, WA3W, RA1E, 1'b1);
            ForwardBVE = fwdSel(RegWriteVM, WA3M, RegWriteVW, WA3W, RA2E, 1'b1);

            MultiBusy = w_cntActive;
            MultiDone = (r_cnt == c_CNT_ONE);

            if (BusyDA) begin
                // Whole pipe frozen; any branch is remembered in r_flushPend.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                StallW = 1'b1;
            end else if (w_br || r_flushPend) begin
                // A live branch and a deferred one collapse into one flush.
                // The instructions in F/D are discarded, so holding them
                // for lu/mc would be pointless.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_lu || w_mc) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign StallCnt = r_stallCnt;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // An in-flight multi op is abandoned; its done pulse never fires.
            r_cnt       <= '0;
            r_busyReg   <= '0;
            r_busyVec   <= 1'b0;
            r_flushPend <= 1'b0;
            r_stallCnt  <= '0;
        end else begin
            // The countdown models a fixed-latency unit, so it runs
            // regardless of pipeline stalls.
            if (w_cntActive) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end else if (w_issue) begin
                r_cnt     <= w_issueLat;
                r_busyReg <= WA3E;
                r_busyVec <= RegWriteVE;
            end

            if (BusyDA) begin
                r_flushPend <= r_flushPend | w_br;
            end else begin
                r_flushPend <= 1'b0;
            end

            if (StallD && (r_stallCnt != c_STALL_MAX)) begin
                r_stallCnt <= r_stallCnt + c_STALL_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_sb
// Description : Self-checking bench for hazard_unit_sb. Directed scenarios
//               followed by constrained-random traffic, all checked against
//               a behavioural model of the hazard rules kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_sb;

    localparam int R         = 5;
    localparam int CW        = 4;
    localparam int SW        = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [R-1:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          MultiD, RegWriteE, RegWriteVE, MemtoRegE, MultiE;
    logic [CW-1:0] LatE;
    logic          PCSrcE, BranchTakenE, PCSrcM, PCSrcW;
    logic          RegWriteM, RegWriteVM, RegWriteW, RegWriteVW, BusyDA;
    logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE, ForwardAVE, ForwardBVE;
    logic          MultiBusy, MultiDone;
    logic [SW-1:0] StallCnt;

    hazard_unit_sb #(.R(R), .CW(CW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .MultiD(MultiD),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .RegWriteVE(RegWriteVE),
        .MemtoRegE(MemtoRegE), .MultiE(MultiE), .LatE(LatE),
        .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
        .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .RegWriteM(RegWriteM), .RegWriteVM(RegWriteVM),
        .RegWriteW(RegWriteW), .RegWriteVW(RegWriteVW),
        .WA3M(WA3M), .WA3W(WA3W), .BusyDA(BusyDA),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAVE(ForwardAVE), .ForwardBVE(ForwardBVE),
        .MultiBusy(MultiBusy), .MultiDone(MultiDone), .StallCnt(StallCnt)
    );

    int nVec = 0;
    int nMis = 0;

    // Reference model state: remaining latency of the outstanding op, its
    // destination, the deferred-flush flag and the stall count.
    int mRemain   = 0;
    int mBusyReg  = 0;
    bit mBusyVec  = 0;
    bit mPend     = 0;
    int mStallCnt = 0;

    // Expected outputs for the current cycle.
    bit eStallF, eStallD, eStallE, eStallM, eStallW, eFlushD, eFlushE;
    bit eBusy, eDone;
    int eFAE, eFBE, eFAVE, eFBVE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest producer of the source register supplies the operand.
    function automatic int modelFwd(input bit weM, input int waM, input bit weW,
                                    input int waW, input int src, input bit vec);
        bit realReg;
        realReg = vec || (src != 0);
        if (realReg && weM && waM == src) return 2;
        if (realReg && weW && waW == src) return 1;
        return 0;
    endfunction

    task automatic computeExpected();
        bit branch, pendingFlush, loadUse, readsBusy, multiBlock;
        {eStallF, eStallD, eStallE, eStallM, eStallW, eFlushD, eFlushE} = '0;
        {eBusy, eDone} = '0;
        eFAE = 0; eFBE = 0; eFAVE = 0; eFBVE = 0;
        if (rst_n) begin
            eFAE  = modelFwd(RegWriteM,  int'(WA3M), RegWriteW,  int'(WA3W), int'(RA1E), 0);
            eFBE  = modelFwd(RegWriteM,  int'(WA3M), RegWriteW,  int'(WA3W), int'(RA2E), 0);
            eFAVE = modelFwd(RegWriteVM, int'(WA3M), RegWriteVW, int'(WA3W), int'(RA1E), 1);
            eFBVE = modelFwd(RegWriteVM, int'(WA3M), RegWriteVW, int'(WA3W), int'(RA2E), 1);
            eBusy = (mRemain > 0);
            eDone = (mRemain == 1);
            branch       = BranchTakenE || PCSrcE || PCSrcM || PCSrcW;
            pendingFlush = branch || mPend;
            loadUse      = MemtoRegE && RegWriteE && WA3E != 0 &&
                           (WA3E == RA1D || WA3E == RA2D);
            readsBusy    = (mBusyVec || mBusyReg != 0) &&
                           (int'(RA1D) == mBusyReg || int'(RA2D) == mBusyReg);
            multiBlock   = (mRemain > 0) && (MultiD || readsBusy);
            if (BusyDA) begin
                {eStallF, eStallD, eStallE, eStallM, eStallW} = 5'b11111;
            end else if (pendingFlush) begin
                eFlushD = 1; eFlushE = 1;
            end else if (loadUse || multiBlock) begin
                eStallF = 1; eStallD = 1; eFlushE = 1;
            end
        end
    endtask

    task automatic checkModel(input string tag);
        computeExpected();
        chk({tag, ".StallF"}, StallF, eStallF);
        chk({tag, ".StallD"}, StallD, eStallD);
        chk({tag, ".StallE"}, StallE, eStallE);
        chk({tag, ".StallM"}, StallM, eStallM);
        chk({tag, ".StallW"}, StallW, eStallW);
        chk({tag, ".FlushD"}, FlushD, eFlushD);
        chk({tag, ".FlushE"}, FlushE, eFlushE);
        chk({tag, ".ForwardAE"}, ForwardAE, eFAE);
        chk({tag, ".ForwardBE"}, ForwardBE, eFBE);
        chk({tag, ".ForwardAVE"}, ForwardAVE, eFAVE);
        chk({tag, ".ForwardBVE"}, ForwardBVE, eFBVE);
        chk({tag, ".MultiBusy"}, MultiBusy, eBusy);
        chk({tag, ".MultiDone"}, MultiDone, eDone);
        chk({tag, ".StallCnt"}, StallCnt, mStallCnt);
    endtask

    // Inputs are driven 1 ns after the rising edge; settle lands on the
    // falling edge where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    task automatic advance();
        bit branch;
        computeExpected();
        @(posedge clk);
        if (!rst_n) begin
            mRemain = 0; mBusyReg = 0; mBusyVec = 0; mPend = 0; mStallCnt = 0;
        end else begin
            branch = BranchTakenE || PCSrcE || PCSrcM || PCSrcW;
            if (eStallD && mStallCnt < STALL_MAX) mStallCnt++;
            mPend = BusyDA ? (mPend || branch) : 1'b0;
            if (mRemain > 0) begin
                mRemain--;
            end else if (MultiE && !BusyDA) begin
                mRemain  = (LatE == 0) ? 1 : int'(LatE);
                mBusyReg = int'(WA3E);
                mBusyVec = RegWriteVE;
            end
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        settle();
        checkModel(tag);
        advance();
    endtask

    task automatic clearInputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {MultiD, RegWriteE, RegWriteVE, MemtoRegE, MultiE} = '0;
        LatE = '0;
        {PCSrcE, BranchTakenE, PCSrcM, PCSrcW} = '0;
        {RegWriteM, RegWriteVM, RegWriteW, RegWriteVW, BusyDA} = '0;
    endtask

    function automatic logic [R-1:0] pickReg();
        int p;
        p = $urandom_range(0, 5);
        if (p == 5) return R'($urandom_range(0, 31));
        return R'(p);
    endfunction

    function automatic bit chance(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    initial begin
        clearInputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mRemain = 0; mBusyReg = 0; mBusyVec = 0; mPend = 0; mStallCnt = 0;

        // Reset state, including a branch that must not leak through.
        PCSrcE = 1; RegWriteM = 1; WA3M = 3; RA1E = 3;
        settle();
        checkModel("reset");
        chk("reset.ForwardAE_forced", ForwardAE, 0);
        chk("reset.FlushD_forced", FlushD, 0);
        chk("reset.StallCnt", StallCnt, 0);
        advance();
        clearInputs();
        rst_n = 1'b1;

        // Forwarding: M over W, then W, scalar r0 excluded, vector r0 valid.
        RegWriteM = 1; RegWriteW = 1; WA3M = 3; WA3W = 3; RA1E = 3;
        settle(); checkModel("fwd1"); chk("fwd.M_priority", ForwardAE, 2); advance();
        RegWriteM = 0;
        settle(); checkModel("fwd2"); chk("fwd.W_only", ForwardAE, 1); advance();
        RegWriteM = 1; WA3M = 0; WA3W = 0; RA1E = 0; RegWriteVM = 1;
        settle(); checkModel("fwd3");
        chk("fwd.scalar_r0", ForwardAE, 0);
        chk("fwd.vector_r0", ForwardAVE, 2);
        advance();
        clearInputs();

        // Load-use on RA2D.
        MemtoRegE = 1; RegWriteE = 1; WA3E = 7; RA2D = 7;
        settle(); checkModel("lu");
        chk("lu.StallD", StallD, 1);
        chk("lu.FlushE", FlushE, 1);
        chk("lu.StallCnt_before", StallCnt, 0);
        advance();
        clearInputs();
        settle(); checkModel("lu_after"); chk("lu.StallCnt_after", StallCnt, 1); advance();

        // Multi-cycle vector op, latency 4, reader of v9 in D.
        MultiE = 1; LatE = 4; WA3E = 9; RegWriteVE = 1;
        cycle("mc_issue");
        clearInputs();
        RA1D = 9;
        for (int k = 1; k <= 4; k++) begin
            settle(); checkModel($sformatf("mc%0d", k));
            chk($sformatf("mc%0d.Busy", k), MultiBusy, 1);
            chk($sformatf("mc%0d.Done", k), MultiDone, (k == 4));
            chk($sformatf("mc%0d.StallD", k), StallD, 1);
            advance();
        end
        settle(); checkModel("mc_end"); chk("mc_end.Busy", MultiBusy, 0); advance();
        clearInputs();

        // Second multi op in D waits for the first to drain.
        MultiE = 1; LatE = 3; WA3E = 9;
        cycle("md_issue");
        clearInputs();
        MultiD = 1;
        for (int k = 1; k <= 4; k++) begin
            settle(); checkModel($sformatf("md%0d", k));
            chk($sformatf("md%0d.StallD", k), StallD, (k <= 3));
            advance();
        end
        clearInputs();

        // Latency 0 behaves as latency 1.
        MultiE = 1; LatE = 0; WA3E = 4;
        cycle("lat0_issue");
        clearInputs();
        settle(); checkModel("lat0_a");
        chk("lat0.Busy", MultiBusy, 1); chk("lat0.Done", MultiDone, 1);
        advance();
        settle(); checkModel("lat0_b"); chk("lat0.Idle", MultiBusy, 0); advance();

        // Scalar destination 0 is never waited on; vector 0 is.
        MultiE = 1; LatE = 2; WA3E = 0;
        cycle("sr0_issue");
        clearInputs();
        settle(); checkModel("sr0"); chk("sr0.noStall", StallD, 0); advance();
        cycle("sr0_drain");
        MultiE = 1; LatE = 2; WA3E = 0; RegWriteVE = 1;
        cycle("vr0_issue");
        clearInputs();
        settle(); checkModel("vr0"); chk("vr0.Stall", StallD, 1); advance();
        cycle("vr0_drain");

        // Branch during BusyDA is deferred to the first free cycle.
        BusyDA = 1; BranchTakenE = 1;
        settle(); checkModel("da1");
        chk("da1.StallW", StallW, 1); chk("da1.FlushD", FlushD, 0);
        advance();
        BranchTakenE = 0;
        cycle("da2");
        cycle("da3");
        BusyDA = 0;
        settle(); checkModel("da_fall");
        chk("da_fall.FlushD", FlushD, 1); chk("da_fall.FlushE", FlushE, 1);
        advance();
        settle(); checkModel("da_after"); chk("da_after.FlushD", FlushD, 0); advance();

        // Flush beats load-use.
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5; PCSrcE = 1;
        settle(); checkModel("br_lu");
        chk("br_lu.FlushD", FlushD, 1); chk("br_lu.StallF", StallF, 0);
        advance();
        clearInputs();

        // Stall counter saturation.
        rst_n = 0; cycle("sat_rst"); rst_n = 1;
        BusyDA = 1;
        for (int k = 0; k < 20; k++) cycle($sformatf("sat%0d", k));
        BusyDA = 0;
        settle(); checkModel("sat_end"); chk("sat.StallCnt", StallCnt, STALL_MAX); advance();

        // Reset abandons an outstanding multi op.
        MultiE = 1; LatE = 5; WA3E = 12;
        cycle("rmc_issue");
        clearInputs();
        cycle("rmc1");
        cycle("rmc2");
        rst_n = 0;
        settle(); checkModel("rmc_rst"); chk("rmc_rst.Busy", MultiBusy, 0); advance();
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            settle(); checkModel($sformatf("rmc_post%0d", k));
            chk($sformatf("rmc_post%0d.Done", k), MultiDone, 0);
            chk($sformatf("rmc_post%0d.Busy", k), MultiBusy, 0);
            advance();
        end

        // Constrained-random traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n        = !chance(80);
            RA1D         = pickReg();
            RA2D         = pickReg();
            RA1E         = pickReg();
            RA2E         = pickReg();
            WA3E         = pickReg();
            WA3M         = pickReg();
            WA3W         = pickReg();
            MultiD       = chance(6);
            RegWriteE    = chance(2);
            RegWriteVE   = chance(2);
            MemtoRegE    = chance(3);
            MultiE       = chance(4);
            LatE         = CW'($urandom_range(0, 15));
            PCSrcE       = chance(15);
            BranchTakenE = chance(15);
            PCSrcM       = chance(20);
            PCSrcW       = chance(20);
            RegWriteM    = chance(2);
            RegWriteVM   = chance(2);
            RegWriteW    = chance(2);
            RegWriteVW   = chance(2);
            BusyDA       = chance(6);
            cycle($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
